// File: rtl/saturation_correction_mult_pipe_pkg.sv
// Shared format and rounding-mode constants for the saturation-correction multiplier.
package saturation_correction_pkg;

    localparam int unsigned A_FRAC_DEF    = 7;
    localparam int unsigned J_FRAC_DEF    = 4;
    localparam int unsigned OUT_W_DEF     = 8;

    localparam int unsigned ROUND_TRUNC   = 0;
    localparam int unsigned ROUND_HALF_UP = 1;

endpackage

// File: rtl/saturation_correction_mult_pipe_if.sv
// Valid/ready stream bundle: Ac/Jc beats in, corrected pixel beats out.
interface saturation_correction_mult_pipe_if #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned A_W      = 10,
    parameter int unsigned J_W      = 10,
    parameter int unsigned OUT_W    = 8
);

    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*A_W-1:0]   ac;
    logic [CHANNELS*J_W-1:0]   jc;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*OUT_W-1:0] pixel;
    logic [CHANNELS-1:0]       sat;

    modport master (
        output in_valid, ac, jc, out_ready,
        input  in_ready, out_valid, pixel, sat
    );

    modport slave (
        input  in_valid, ac, jc, out_ready,
        output in_ready, out_valid, pixel, sat
    );

endinterface

// File: rtl/saturation_correction_mult_pipe_lane.sv
// One colour lane: S2 full product, S3 round + clip to the unsigned pixel range.
module sc_mul_lane
    import saturation_correction_pkg::*;
#(
    parameter int unsigned A_W    = 10,
    parameter int unsigned A_FRAC = A_FRAC_DEF,
    parameter int unsigned J_W    = 10,
    parameter int unsigned J_FRAC = J_FRAC_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned ROUND  = ROUND_HALF_UP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld2_i,
    input  logic             ld3_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [J_W-1:0]   j_i,
    output logic [OUT_W-1:0] pixel_o,
    output logic             sat_o
);

    localparam int unsigned P_W = A_W + J_W;
    localparam int unsigned F   = A_FRAC + J_FRAC;
    localparam int unsigned R_W = P_W + 1 - F;

    // Half-LSB bias added before the shift; zero when truncating.
    localparam logic [P_W:0]   RND_ADD = (ROUND == ROUND_HALF_UP) ? ((P_W + 1)'(1) << (F - 1)) : '0;
    localparam logic [R_W-1:0] PIX_MAX = R_W'({OUT_W{1'b1}});

    logic [P_W-1:0]   p_d;
    logic [P_W-1:0]   p_q;
    logic [P_W:0]     p_rnd;
    logic [R_W-1:0]   r;
    logic [OUT_W-1:0] pixel_d;
    logic             sat_d;

    assign p_d = P_W'(a_i) * P_W'(j_i);

    // Round in one extra bit so the bias cannot overflow, then clip instead of wrapping.
    always_comb begin
        p_rnd   = {1'b0, p_q} + RND_ADD;
        r       = R_W'(p_rnd >> F);
        pixel_d = r[OUT_W-1:0];
        sat_d   = 1'b0;
        if (r > PIX_MAX) begin
            pixel_d = '1;
            sat_d   = 1'b1;
        end
    end

    // S2 product and S3 result registers, loaded only when a beat moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            pixel_o <= '0;
            sat_o   <= 1'b0;
        end else begin
            if (ld2_i) begin
                p_q <= p_d;
            end
            if (ld3_i) begin
                pixel_o <= pixel_d;
                sat_o   <= sat_d;
            end
        end
    end

endmodule

// File: rtl/saturation_correction_mult_pipe.sv
// Three-stage multi-lane Ac*Jc multiplier with rounding, clipping and a clip-event counter.
module saturation_correction_mult_pipe
    import saturation_correction_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned A_W      = 10,
    parameter int unsigned A_FRAC   = A_FRAC_DEF,
    parameter int unsigned J_W      = 10,
    parameter int unsigned J_FRAC   = J_FRAC_DEF,
    parameter int unsigned OUT_W    = OUT_W_DEF,
    parameter int unsigned ROUND    = ROUND_HALF_UP,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    saturation_correction_mult_pipe_if.slave  bus,
    output logic [CNT_W-1:0]                  sat_count
);

    logic                    v1_q, v2_q, v3_q;
    logic                    en1, en2, en3;
    logic [CHANNELS*A_W-1:0] ac_q;
    logic [CHANNELS*J_W-1:0] jc_q;
    logic [CNT_W-1:0]        sat_count_d;
    logic [CNT_W-1:0]        sat_count_q;

    // A stage may advance when it is empty or the stage after it advances.
    assign en3          = !v3_q || bus.out_ready;
    assign en2          = !v2_q || en3;
    assign en1          = !v1_q || en2;
    assign bus.in_ready = en1;
    assign bus.out_valid = v3_q;
    assign sat_count    = sat_count_q;

    // Stage valid bits; bubbles collapse because each stage loads whenever it is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (en1) v1_q <= bus.in_valid;
            if (en2) v2_q <= v1_q;
            if (en3) v3_q <= v2_q;
        end
    end

    // S1 operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q <= '0;
            jc_q <= '0;
        end else if (en1 && bus.in_valid) begin
            ac_q <= bus.ac;
            jc_q <= bus.jc;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        sc_mul_lane #(
            .A_W    (A_W),
            .A_FRAC (A_FRAC),
            .J_W    (J_W),
            .J_FRAC (J_FRAC),
            .OUT_W  (OUT_W),
            .ROUND  (ROUND)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .ld2_i   (en2 && v1_q),
            .ld3_i   (en3 && v2_q),
            .a_i     (ac_q[g*A_W +: A_W]),
            .j_i     (jc_q[g*J_W +: J_W]),
            .pixel_o (bus.pixel[g*OUT_W +: OUT_W]),
            .sat_o   (bus.sat[g])
        );
    end

    // Count delivered beats with any lane clipped, sticking at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (v3_q && bus.out_ready && (|bus.sat) && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    // Clip-event counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

endmodule

// File: tb/tb_saturation_correction_mult_pipe.sv
// Bench: a rounding build and a truncating/narrow-counter build driven in lockstep, scoreboard-checked.
module tb_saturation_correction_mult_pipe;
    import saturation_correction_pkg::*;

    localparam int unsigned CH     = 3;
    localparam int unsigned A_W    = 10;
    localparam int unsigned J_W    = 10;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned CNT_W0 = 16;
    localparam int unsigned CNT_W1 = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic [CH*A_W-1:0]      ac = '0;
    logic [CH*J_W-1:0]      jc = '0;
    logic [CNT_W0-1:0]      sat_count0;
    logic [CNT_W1-1:0]      sat_count1;

    int n_vec = 0;
    int n_err = 0;
    int cnt0_m = 0;
    int cnt1_m = 0;

    typedef struct {
        logic [CH*OUT_W-1:0] pix0;
        logic [CH-1:0]       sat0;
        logic [CH*OUT_W-1:0] pix1;
        logic [CH-1:0]       sat1;
    } exp_t;

    exp_t sb[$];

    saturation_correction_mult_pipe_if #(.CHANNELS(CH), .A_W(A_W), .J_W(J_W), .OUT_W(OUT_W)) bus0 ();
    saturation_correction_mult_pipe_if #(.CHANNELS(CH), .A_W(A_W), .J_W(J_W), .OUT_W(OUT_W)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.ac        = ac;
    assign bus0.jc        = jc;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.ac        = ac;
    assign bus1.jc        = jc;
    assign bus1.out_ready = out_ready;

    saturation_correction_mult_pipe #(
        .CHANNELS(CH), .A_W(A_W), .A_FRAC(7), .J_W(J_W), .J_FRAC(4),
        .OUT_W(OUT_W), .ROUND(ROUND_HALF_UP), .CNT_W(CNT_W0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sat_count(sat_count0)
    );

    saturation_correction_mult_pipe #(
        .CHANNELS(CH), .A_W(A_W), .A_FRAC(7), .J_W(J_W), .J_FRAC(4),
        .OUT_W(OUT_W), .ROUND(ROUND_TRUNC), .CNT_W(CNT_W1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .sat_count(sat_count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: Q3.7 * Q6.4 -> integer pixel with optional half-up rounding and clipping.
    function automatic void model(input logic [CH*A_W-1:0] a, input logic [CH*J_W-1:0] j, input bit rnd,
                                  output logic [CH*OUT_W-1:0] pix, output logic [CH-1:0] s);
        longint p, r;
        for (int l = 0; l < CH; l++) begin
            p = longint'(a[l*A_W +: A_W]) * longint'(j[l*J_W +: J_W]);
            r = rnd ? (p + 1024) / 2048 : p / 2048;
            if (r > 255) begin
                pix[l*OUT_W +: OUT_W] = 8'hff;
                s[l] = 1'b1;
            end else begin
                pix[l*OUT_W +: OUT_W] = 8'(r);
                s[l] = 1'b0;
            end
        end
    endfunction

    // Scoreboard: push on input transfer, compare head while output is presented, pop on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            cnt0_m = 0;
            cnt1_m = 0;
        end else begin
            chk("in_ready", bus0.in_ready, (sb.size() < 3) || out_ready);
            chk("sat_count0", sat_count0, cnt0_m);
            chk("sat_count1", sat_count1, cnt1_m);
            if (bus0.out_valid || bus1.out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = sb[0];
                    chk("out_valid0", bus0.out_valid, 1);
                    chk("out_valid1", bus1.out_valid, 1);
                    chk("pixel0", bus0.pixel, e.pix0);
                    chk("sat0", bus0.sat, e.sat0);
                    chk("pixel1", bus1.pixel, e.pix1);
                    chk("sat1", bus1.sat, e.sat1);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        if ((|e.sat0) && cnt0_m < 65535) cnt0_m++;
                        if ((|e.sat1) && cnt1_m < 15) cnt1_m++;
                    end
                end
            end
            if (in_valid && bus0.in_ready) begin
                model(ac, jc, 1'b1, e.pix0, e.sat0);
                model(ac, jc, 1'b0, e.pix1, e.sat1);
                sb.push_back(e);
            end
        end
    end

    // Offer one beat until accepted; optionally toggle out_ready pseudo-randomly each cycle.
    task automatic send_beat(input logic [CH*A_W-1:0] a, input logic [CH*J_W-1:0] j, input bit rand_rdy);
        bit done;
        int guard;
        done = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        ac = a;
        jc = j;
        while (!done) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = bus0.in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 50) begin
                chk("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe with out_ready high; returns latency and the presented outputs.
    task automatic single_beat(input logic [CH*A_W-1:0] a, input logic [CH*J_W-1:0] j, output int lat,
                               output logic [CH*OUT_W-1:0] p0, output logic [CH*OUT_W-1:0] p1,
                               output logic [CH-1:0] s0, output logic [CH-1:0] s1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ac = a;
        jc = j;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus0.out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        p0 = bus0.pixel;
        p1 = bus1.pixel;
        s0 = bus0.sat;
        s1 = bus1.sat;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [CH*OUT_W-1:0] p0, p1;
        logic [CH-1:0] s0, s1;
        logic [CH*A_W-1:0] ra;
        logic [CH*J_W-1:0] rj;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_in_ready", bus0.in_ready, 1);
        chk("rst_pixel", bus0.pixel, 0);
        chk("rst_sat_count", sat_count0, 0);
        @(posedge clk);
        #1;

        // 1.0 * 50.0
        single_beat({20'd0, 10'd128}, {20'd0, 10'd800}, lat, p0, p1, s0, s1);
        chk("lat_first", lat, 3);
        chk("pix_50", p0[7:0], 50);
        chk("sat_50", s0, 0);
        @(negedge clk);
        chk("cnt_after_50", sat_count0, 0);
        @(posedge clk);
        #1;

        // 1.0 * 50.5: rounding build gives 51, truncating build 50
        single_beat({20'd0, 10'd128}, {20'd0, 10'd808}, lat, p0, p1, s0, s1);
        chk("pix_round", p0[7:0], 51);
        chk("pix_trunc", p1[7:0], 50);
        @(posedge clk);
        #1;

        // Full-scale on all lanes clips every lane
        single_beat({3{10'd1023}}, {3{10'd1023}}, lat, p0, p1, s0, s1);
        chk("pix_full", p0, 24'hffffff);
        chk("sat_full", s0, 3'b111);
        @(negedge clk);
        chk("cnt_after_full", sat_count0, 1);
        @(posedge clk);
        #1;

        // 4.0 * 63.9375 = 255.75: rounds to 256 -> clipped; truncates to exactly 255 -> not clipped
        single_beat({20'd0, 10'd512}, {20'd0, 10'd1023}, lat, p0, p1, s0, s1);
        chk("pix_512_round", p0[7:0], 255);
        chk("sat_512_round", s0[0], 1);
        chk("pix_512_trunc", p1[7:0], 255);
        chk("sat_512_trunc", s1[0], 0);
        @(posedge clk);
        #1;

        // Random stream with pseudo-random backpressure
        for (int i = 0; i < 10; i++) begin
            ra = CH*A_W'($urandom);
            rj = CH*J_W'($urandom);
            send_beat(ra, rj, 1'b1);
        end
        // Saturating stream to pin the narrow counter
        for (int i = 0; i < 21; i++) begin
            for (int l = 0; l < CH; l++) begin
                ra[l*A_W +: A_W] = 10'($urandom_range(900, 1023));
                rj[l*J_W +: J_W] = 10'($urandom_range(900, 1023));
            end
            send_beat(ra, rj, 1'b1);
        end
        drain();
        @(negedge clk);
        chk("cnt1_sticky", sat_count1, 15);
        @(posedge clk);
        #1;

        // Fill the pipe with out_ready low, then reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_beat({3{10'd300}}, {3{10'd200}}, 1'b0);
        end
        @(negedge clk);
        chk("full_in_ready", bus0.in_ready, 0);
        chk("full_out_valid", bus0.out_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus0.out_valid, 0);
        chk("mid_rst_pixel", bus0.pixel, 0);
        chk("mid_rst_sat_count", sat_count0, 0);
        chk("mid_rst_in_ready", bus0.in_ready, 1);
        @(posedge clk);
        #1;

        // 2.0 * 25.0 after reset
        single_beat({20'd0, 10'd256}, {20'd0, 10'd400}, lat, p0, p1, s0, s1);
        chk("lat_after_rst", lat, 3);
        chk("pix_after_rst", p0[7:0], 50);
        drain();
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/saturation_correction_mult_pipe.md
# saturation_correction_mult_pipe

Parametrised, multi-channel pipelined multiplier for the SRSC saturation-correction stage. Computes Ac·Jc per colour channel in fixed point, with selectable rounding and output saturation instead of bit-slice wrap. Uses a valid/ready stream interface with backpressure. Sits between the Ac/Jc power-term generators and the output pixel packer, and counts saturation events for tuning β.

## Interface
Parameters:
- CHANNELS, 3: number of colour lanes processed in parallel.
- A_W, 10: Ac word width; A_FRAC, 7: Ac fractional bits (Q3.7).
- J_W, 10: Jc word width; J_FRAC, 4: Jc fractional bits (Q6.4).
- OUT_W, 8: unsigned output pixel width.
- ROUND, 1: 0 = truncate, 1 = round half up.
- CNT_W, 16: saturation event counter width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- ac  in  CHANNELS*A_W  Ac per lane; lane 0 in the LSBs.
- jc  in  CHANNELS*J_W  Jc per lane; lane 0 in the LSBs.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts a beat.
- pixel  out  CHANNELS*OUT_W  corrected pixel per lane.
- sat  out  CHANNELS  per-lane flag: this beat was clipped.
- sat_count  out  CNT_W  number of beats with any lane clipped; sticks at all-ones.

## Operation
- A beat transfers on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- Pipeline stages:
  - S1 registers ac and jc.
  - S2 registers the full product: A_W+J_W bits, F = A_FRAC+J_FRAC fractional bits (Q9.11 at defaults).
  - S3 applies rounding and saturation, then registers pixel and sat.
- Each stage has a valid bit v1..v3. Stage enables:
  - en3 = !v3 | out_ready
  - en2 = !v2 | en3
  - en1 = !v1 | en2
  - in_ready = en1
  - Bubbles collapse. No beat is dropped or duplicated.
- Arithmetic per lane, unsigned:
  - ROUND=1: r = (p + 2^(F-1)) >> F, computed one bit wider than p so the addition cannot overflow.
  - ROUND=0: r = p >> F.
  - If r > 2^OUT_W−1, then pixel = 2^OUT_W−1 and sat = 1. Otherwise pixel = r[OUT_W-1:0] and sat = 0.
- sat_count increments by 1 on each output transfer where |sat is set. It saturates at 2^CNT_W−1.
- While out_valid & !out_ready, pixel and sat hold stable.
- Reset: v1..v3, pixel, sat and sat_count all go to 0, and out_valid goes to 0. in_ready is 1 in the first cycle after reset. A reset mid-stream discards in-flight beats; no partial output appears.
- Simultaneous input accept and output transfer on a full pipeline are legal. Throughput is 1 beat/cycle.

## Timing
- Latency: 3 cycles from input transfer to out_valid, with out_ready held high.
- in_ready is combinational from out_ready through the enable chain. It does not depend on in_valid.
- A full pipeline holds 3 beats. With out_ready low, in_ready drops in the cycle after v1, v2 and v3 are all set.
- sat_count updates in the cycle after the output transfer.

## Structure
- Shared package saturation_correction_pkg holds:
  - format constants: default A_FRAC, J_FRAC, OUT_W;
  - the rounding-mode localparams ROUND_TRUNC = 0 and ROUND_HALF_UP = 1.
- Sub-module sc_mul_lane, instantiated CHANNELS times: one lane's S2 product and S3 round/saturate datapath, with shared enables passed in. Valid bits, enables and sat_count stay in the top level.

## Test plan
- Reset, then ac lane0 = 128 (1.0), jc lane0 = 800 (50.0), out_ready = 1 → after 3 cycles: pixel lane0 = 50, sat = 0, sat_count = 0.
- Ac = 128, Jc = 808 (50.5):
  - ROUND=1 → 51.
  - ROUND=0 → 50.
  - The two builds differ only in this LSB.
- Ac = 1023, Jc = 1023 on all lanes → pixel = 255 on every lane, sat = 3'b111, sat_count = 1. The old [18:11] slice gives wrapped 255 here; also check Ac = 512, Jc = 1023 → 255 saturated (not the wrapped value).
- Stream 10 beats with out_ready toggling pseudo-randomly:
  - output sequence equals input sequence, with no loss or duplication;
  - pixel is stable whenever out_valid & !out_ready;
  - in_ready is 0 when 3 beats are held.
- Assert rst while 3 beats are in flight → next cycle out_valid = 0, pixel = 0, sat_count = 0, in_ready = 1. The next accepted beat emerges after 3 cycles.
- Force 2^CNT_W+5 saturating beats (CNT_W = 4 build) → sat_count sticks at 15.
